// File: rtl/syn_lb_pkg.sv
// Shared types and constants for the local-bus initiator.
package syn_lb_pkg;

  // Transaction sequencing states of the LB initiator.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } lb_mstr_st_t;

  // Read data returned for writes and for timed-out transactions (sliced to DATA_W).
  localparam logic [63:0] LB_ERR_RDATA = 64'h0;

  // A slave acknowledge only counts when its kind matches the issued strobe.
  function automatic logic lb_match(input logic wr, input logic rd_valid, input logic wr_valid);
    return wr ? wr_valid : rd_valid;
  endfunction

endpackage

// File: rtl/syn_lb_mstr.sv
// Local-bus initiator: one host command in, one LB strobe out, one response back.
// Waits for the matching slave acknowledge or gives up after TIMEOUT cycles.
module syn_lb_mstr #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int TMR_W   = 8
) (
  input  logic              clk_ir,
  input  logic              rst_sync,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_wr,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              lb_rd_en,
  output logic              lb_wr_en,
  output logic [ADDR_W-1:0] lb_addr,
  output logic [DATA_W-1:0] lb_wr_data,
  input  logic              lb_rd_valid,
  input  logic              lb_wr_valid,
  input  logic [DATA_W-1:0] lb_rd_data,
  output logic              stray_ack
);

  import syn_lb_pkg::*;

  // Timer value on the last WAIT cycle before giving up.
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0] ERR_DATA = LB_ERR_RDATA[DATA_W-1:0];

  lb_mstr_st_t       state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] lb_addr_q, lb_addr_d;
  logic [DATA_W-1:0] lb_wr_data_q, lb_wr_data_d;
  logic              lb_rd_en_q, lb_rd_en_d;
  logic              lb_wr_en_q, lb_wr_en_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_wr_q, rsp_wr_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              stray_q, stray_d;
  logic              match_s;
  logic              busy_s;

  // Next-state, response capture and strobe generation.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    wr_d         = wr_q;
    lb_addr_d    = lb_addr_q;
    lb_wr_data_d = lb_wr_data_q;
    lb_rd_en_d   = 1'b0;
    lb_wr_en_d   = 1'b0;
    rsp_wr_d     = rsp_wr_q;
    rsp_err_d    = rsp_err_q;
    rsp_rdata_d  = rsp_rdata_q;
    match_s      = lb_match(wr_q, lb_rd_valid, lb_wr_valid);
    busy_s       = (state_q == ISSUE) || (state_q == WAIT);

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          // Strobes are registered, so they rise together with ISSUE.
          state_d      = ISSUE;
          wr_d         = cmd_wr;
          lb_addr_d    = cmd_addr;
          lb_wr_data_d = cmd_wdata;
          lb_rd_en_d   = ~cmd_wr;
          lb_wr_en_d   = cmd_wr;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (match_s) begin
          // Combinational slave: acknowledge arrives with the strobe.
          state_d     = RESP;
          rsp_wr_d    = wr_q;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = wr_q ? ERR_DATA : lb_rd_data;
        end else begin
          state_d = WAIT;
          timer_d = '0;
        end
      end
      WAIT: begin
        timer_d = timer_q + TMR_W'(1);
        if (match_s) begin
          // A match on the final cycle still wins over the timeout.
          state_d     = RESP;
          rsp_wr_d    = wr_q;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = wr_q ? ERR_DATA : lb_rd_data;
        end else if (timer_q == TMR_LAST) begin
          state_d     = RESP;
          rsp_wr_d    = wr_q;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = ERR_DATA;
        end else begin
          state_d = WAIT;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    cmd_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    // Any acknowledge that does not complete the outstanding command is stray.
    stray_d = (lb_rd_valid && !(busy_s && !wr_q)) ||
              (lb_wr_valid && !(busy_s &&  wr_q));
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_ir) begin
    if (rst_sync) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      wr_q         <= 1'b0;
      lb_addr_q    <= '0;
      lb_wr_data_q <= '0;
      lb_rd_en_q   <= 1'b0;
      lb_wr_en_q   <= 1'b0;
      cmd_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_wr_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_rdata_q  <= '0;
      stray_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      wr_q         <= wr_d;
      lb_addr_q    <= lb_addr_d;
      lb_wr_data_q <= lb_wr_data_d;
      lb_rd_en_q   <= lb_rd_en_d;
      lb_wr_en_q   <= lb_wr_en_d;
      cmd_ready_q  <= cmd_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_wr_q     <= rsp_wr_d;
      rsp_err_q    <= rsp_err_d;
      rsp_rdata_q  <= rsp_rdata_d;
      stray_q      <= stray_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_wr     = rsp_wr_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign lb_rd_en   = lb_rd_en_q;
  assign lb_wr_en   = lb_wr_en_q;
  assign lb_addr    = lb_addr_q;
  assign lb_wr_data = lb_wr_data_q;
  assign stray_ack  = stray_q;

endmodule
